// File: rtl/mem_copy_pkg.sv
// Shared definitions for the block-transfer engine.
//
// Contents:
//   state_t   - controller states (idle, read, write, finish)
//   MODE_COPY - mode encoding for memory-to-memory copy
//   MODE_FILL - mode encoding for constant fill
package mem_copy_pkg;

  // Controller states. RD and WR are the only states that own the memory
  // port. FIN is a single-cycle completion state.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RD   = 2'd1,
    WR   = 2'd2,
    FIN  = 2'd3
  } state_t;

  // Transfer mode as presented on the mode input.
  localparam logic MODE_COPY = 1'b0;
  localparam logic MODE_FILL = 1'b1;

endpackage

// File: rtl/mem_copy_engine.sv
// Block-transfer initiator on the data-memory port.
//
// Copies len words from src to dst, one read followed by one write per word.
// In fill mode it writes fill_val to len words starting at dst. All request
// fields are captured when a start is accepted in IDLE, so later changes on
// the request inputs do not affect a transfer in flight.
//
// Ports:
//   clk       - single clock, all state changes on its rising edge
//   rst       - synchronous active-high reset, aborts any transfer
//   start     - transfer request, only looked at in IDLE
//   mode      - 0 = copy, 1 = fill
//   src       - source base address (copy only)
//   dst       - destination base address
//   len       - word count, 0 completes immediately, DEPTH is allowed
//   fill_val  - pattern written in fill mode
//   busy      - high while the engine owns the memory port (RD/WR)
//   done      - one-cycle completion pulse
//   mem_addr  - memory address, zero when the engine is not busy
//   mem_wdata - memory write data, zero unless writing
//   mem_we    - memory write enable
//   mem_rdata - memory read data, combinational from mem_addr
module mem_copy_engine
  import mem_copy_pkg::*;
#(
  parameter int WIDTH    = 16,
  parameter int DEPTH    = 1024,
  parameter int ADD_SIZE = $clog2(DEPTH),
  parameter int LEN_SIZE = ADD_SIZE + 1
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                mode,
  input  logic [ADD_SIZE-1:0] src,
  input  logic [ADD_SIZE-1:0] dst,
  input  logic [LEN_SIZE-1:0] len,
  input  logic [WIDTH-1:0]    fill_val,
  output logic                busy,
  output logic                done,
  output logic [ADD_SIZE-1:0] mem_addr,
  output logic [WIDTH-1:0]    mem_wdata,
  output logic                mem_we,
  input  logic [WIDTH-1:0]    mem_rdata
);

  state_t              state;
  state_t              next_state;

  logic                mode_reg;
  logic [ADD_SIZE-1:0] src_ptr;
  logic [ADD_SIZE-1:0] dst_ptr;
  logic [LEN_SIZE-1:0] remaining;
  logic [WIDTH-1:0]    fill_reg;
  logic [WIDTH-1:0]    data_reg;

  logic                len_zero;
  logic                last_word;

  assign len_zero  = (len == '0);
  assign last_word = (remaining == LEN_SIZE'(1));

  // State register. Reset returns to IDLE immediately, which abandons any
  // transfer in progress without passing through FIN, so no done pulse.
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state and output decode. The port is driven to zero outside RD/WR
  // so the memory sees an inert interface whenever the core may own it.
  // The write enable is masked by rst so that asserting reset during a WR
  // cycle prevents the write that would otherwise land on that same edge.
  always_comb begin
    next_state = state;
    busy       = 1'b0;
    done       = 1'b0;
    mem_addr   = '0;
    mem_wdata  = '0;
    mem_we     = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          if (len_zero) begin
            next_state = FIN;
          end else if (mode == MODE_FILL) begin
            next_state = WR;
          end else begin
            next_state = RD;
          end
        end
      end
      RD: begin
        busy       = 1'b1;
        mem_addr   = src_ptr;
        next_state = WR;
      end
      WR: begin
        busy      = 1'b1;
        mem_addr  = dst_ptr;
        mem_we    = ~rst;
        mem_wdata = (mode_reg == MODE_FILL) ? fill_reg : data_reg;
        if (last_word) begin
          next_state = FIN;
        end else if (mode_reg == MODE_FILL) begin
          next_state = WR;
        end else begin
          next_state = RD;
        end
      end
      FIN: begin
        done       = 1'b1;
        next_state = IDLE;
      end
      default: begin
        next_state = IDLE;
      end
    endcase
  end

  // Datapath: request latches, pointers, word counter and read buffer.
  // Request fields are captured only on an accepted non-empty start, so a
  // start seen while busy (or in FIN) cannot disturb the running transfer.
  // Pointers are ADD_SIZE bits wide and wrap naturally at the top of memory.
  always_ff @(posedge clk) begin
    if (rst) begin
      mode_reg  <= MODE_COPY;
      src_ptr   <= '0;
      dst_ptr   <= '0;
      remaining <= '0;
      fill_reg  <= '0;
      data_reg  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (start && !len_zero) begin
            mode_reg  <= mode;
            src_ptr   <= src;
            dst_ptr   <= dst;
            remaining <= len;
            fill_reg  <= fill_val;
          end
        end
        RD: begin
          data_reg <= mem_rdata;
        end
        WR: begin
          src_ptr   <= src_ptr + ADD_SIZE'(1);
          dst_ptr   <= dst_ptr + ADD_SIZE'(1);
          remaining <= remaining - LEN_SIZE'(1);
        end
        default: begin
        end
      endcase
    end
  end

endmodule

// File: doc/mem_copy_engine.md
Name: mem_copy_engine

Overview:
- Block-transfer initiator on the data-memory port: copies N words from src to dst, or fills N words with a constant.
- Sits between the CPU control path (start/status) and the 16-bit data memory.
- Drives the memory's addr/wdata/we and consumes its combinational (same-cycle) read data.
- Lets the core offload memcpy/memset; the core must not access data memory while busy=1.

Parameters:
- WIDTH, 16, data word width.
- DEPTH, 1024, memory words.
- ADD_SIZE, $clog2(DEPTH), address width.
- LEN_SIZE, ADD_SIZE+1, length field width; allows len = DEPTH.

Ports:
- clk  in  1  single clock; all state updates on posedge clk.
- rst  in  1  reset, synchronous and active-high.
- start  in  1  request; sampled only in IDLE.
- mode  in  1  0 = COPY, 1 = FILL; latched at start.
- src  in  ADD_SIZE  source base address, COPY only; latched at start.
- dst  in  ADD_SIZE  destination base address; latched at start.
- len  in  LEN_SIZE  word count; latched at start.
- fill_val  in  WIDTH  fill pattern, FILL only; latched at start.
- busy  out  1  high while a transfer owns the memory port.
- done  out  1  one-cycle completion pulse.
- mem_addr  out  ADD_SIZE  memory address.
- mem_wdata  out  WIDTH  memory write data.
- mem_we  out  1  memory write enable.
- mem_rdata  in  WIDTH  memory read data, combinational from mem_addr.

Behaviour:
- States: IDLE, RD, WR, FIN.
- Reset (rst=1 at an edge): state=IDLE; busy=0, done=0, mem_we=0, mem_addr=0, mem_wdata=0; all internal counters and latches cleared.
- Reset mid-transfer aborts the transfer immediately. No write occurs in the reset cycle or after it. done does not pulse.
- IDLE, start=1 and len!=0:
  - Latch mode, src, dst, len, fill_val.
  - Go to RD if COPY, WR if FILL.
- IDLE, start=1 and len=0: go to FIN, so done pulses with no memory write.
- RD (COPY only):
  - mem_addr = src_ptr, mem_we=0.
  - At the clock edge, capture mem_rdata into data_reg; go to WR.
- WR:
  - mem_addr = dst_ptr, mem_we=1.
  - mem_wdata = data_reg in COPY, latched fill_val in FILL.
  - At the edge: increment src_ptr and dst_ptr, decrement remaining.
  - If remaining was 1, go to FIN. Otherwise go to RD (COPY) or stay in WR (FILL).
- FIN: done=1 and busy=0 for exactly one cycle; then IDLE. start is ignored in FIN.
- busy=1 exactly in states RD and WR. mem_we=1 only in WR.
- In IDLE/FIN: mem_addr=0, mem_wdata=0, so the port is inert.
- Latency, start sampled at edge T:
  - COPY: busy over cycles T+1..T+2N, done at T+2N+1.
  - FILL: busy over T+1..T+N, done at T+N+1.
  - len=0: done at T+1.
- Address arithmetic: pointers are ADD_SIZE bits and wrap modulo DEPTH (DEPTH-1 + 1 = 0). No error flag.
- Overlap: copy is strictly ascending, one read then one write per word. If dst is in (src, src+len), results propagate forward. This is defined behaviour, not an error.
- start asserted while busy: ignored, with no effect on latched fields.
- Input changes after start: src/dst/len/mode/fill_val changes have no effect until the next accepted start.

Decomposition:
- Package mem_copy_pkg holds:
  - state enum typedef {IDLE, RD, WR, FIN};
  - mode constants MODE_COPY=0, MODE_FILL=1.
- No sub-module. FSM, pointers and counter live in one module.
- The bench instantiates the existing data memory as the responder on mem_*.

Test Plan:
- COPY: preload mem[0..3]=16'h1111,2222,3333,4444; start src=0 dst=100 len=4 → mem[100..103] equal those values, busy high 8 cycles, done one cycle at T+9, mem[0..3] unchanged.
- FILL: dst=500 len=3 fill_val=16'hBEEF → mem[500..502]=BEEF, mem[503] untouched, done at T+4.
- Wrap: COPY src=1022 dst=10 len=4 → reads 1022,1023,0,1 in that order; FILL dst=1023 len=2 → writes 1023 then 0.
- len=0 → no mem_we pulse at all, done=1 at T+1, busy never high.
- start pulsed during a transfer with different dst → ignored; original transfer completes unchanged.
- rst=1 during the third WR of a len=8 fill → next cycle IDLE, mem_we=0, only 2 words written, no done; a new start then works normally.
